rb_addr_sequencer: RTL and testbench
====================================

# rb_addr_sequencer

Parametrised address sequencer for the row-buffer (RB) BRAM in the neighbourhood image-processing datapath. It generates the external-memory pixel address, the interleaved RB write address and the RB read address, and adds frame-level control the fixed-size generator lacks: start/busy/done handshake, row and frame counting, ring-buffer row tracking, and a window-ready flag. It sits between the pipeline controller, which drives the enables, and the BRAM and external-memory ports.

## Interface
- `RBS`, 4: number of row buffers; power of two, ≥2.
- `RB_DEPTH`, 512: pixels per row, which is also locations per RB; power of two.
- `IMG_ROWS`, 512: image rows per frame; ≥`RBS`.
- `EMEM_AW`, 18: external-memory address width.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset; dominates every other input.
- `start` input 1: frame-start pulse; honoured only in IDLE.
- `en_e_mem_addr` input 1: advance the external-memory address.
- `en_w_bram_addr` input 1: advance the RB write sequence.
- `en_r_bram_addr` input 1: advance the RB read sequence.
- `E_MEM_ADDR` output `EMEM_AW`: external-memory pixel address.
- `W_BRAM_ADDR` output $clog2(RBS*RB_DEPTH): interleaved write address.
- `R_BRAM_ADDR` output $clog2(RB_DEPTH): read address (wide port, all RBs per word).
- `wr_row` output $clog2(RBS): RB currently being written.
- `rd_top_row` output $clog2(RBS): oldest RB, equal to (`wr_row`+1) mod `RBS`.
- `window_valid` output 1: at least `RBS`-1 complete rows are buffered in this frame.
- `row_done` output 1: one-cycle pulse when a write row completes.
- `frame_done` output 1: one-cycle pulse at frame completion.
- `busy` output 1: high while in RUN or DONE.

## Operation
- States:
  - IDLE: enables are ignored and all outputs hold. `start` goes to RUN, clears the write, read and row counters, sets `busy`=1 and reloads `E_MEM_ADDR` to all-ones (see Configuration).
  - RUN: enables are honoured.
  - DONE: lasts one cycle with `frame_done`=1, then returns to IDLE with `busy`=0.
- `E_MEM_ADDR`: increments by 1 on `en_e_mem_addr`, modulo 2^`EMEM_AW`. It starts at all-ones, so the first enabled cycle yields 0.
- Write sequence:
  - On `en_w_bram_addr`, `W_BRAM_ADDR` takes the value loc*`RBS` + `wr_row`, computed from the pre-increment counters.
  - loc then increments. At `RB_DEPTH`-1, loc wraps to 0, `wr_row` advances modulo `RBS`, `row_done` pulses and the written-row count increments.
- Write completion: after `IMG_ROWS` rows, the write side is done and further `en_w_bram_addr` is ignored.
- Read sequence:
  - On `en_r_bram_addr`, `R_BRAM_ADDR` increments and wraps to 0 after `RB_DEPTH`-1; each wrap counts one read row.
  - After `IMG_ROWS` read rows, the read side is done and further reads are ignored.
- RUN→DONE: taken in the cycle in which both sides are done.
- `window_valid`: set when the written-row count reaches `RBS`-1; cleared by `start` and by `rst`.
- Simultaneous enables: all three advance independently in the same cycle.
- `start` while busy: ignored.

## Timing
- All outputs are registered. An enable sampled high at edge N shows its updated address after edge N, with no further latency.
- `row_done`, `wr_row`, `rd_top_row` and `window_valid` update on the same edge as the last write of a row.
- `frame_done` is high in the cycle after the edge that completes the second side, for exactly one cycle. `busy` falls on the following edge.
- Reset values:
  - `E_MEM_ADDR`: all-ones.
  - `W_BRAM_ADDR`, `R_BRAM_ADDR`, `wr_row`: 0.
  - `rd_top_row`: 1.
  - `window_valid`, `row_done`, `frame_done`, `busy`: 0.
  - State: IDLE.
- Reset mid-frame: all of the above are restored on the reset edge, with no completion pulse. Enables asserted in the same cycle as `rst` have no effect.

## Configuration
- `ADDRGEN_MULTIFRAME_EN` defined: `start` does not reload `E_MEM_ADDR`. Successive frames read contiguous external memory, and the address continues modulo 2^`EMEM_AW`.
- `ADDRGEN_MULTIFRAME_EN` undefined: `start` reloads `E_MEM_ADDR` to all-ones, so every frame starts at address 0.

## Test plan
All scenarios use `RBS`=4, `RB_DEPTH`=8, `IMG_ROWS`=6.
- Reset, then no stimulus → every output holds its reset value; `rd_top_row`=1.
- `start`, then 9 consecutive `en_w_bram_addr` → `W_BRAM_ADDR` = 0,4,8,…,28, then 1. `row_done` pulses once after the 8th write and `wr_row` goes 0→1.
- 32 writes → `window_valid` rises after write 24. After write 32, `wr_row` returns to 0 and `rd_top_row`=1.
- 48 writes plus 48 reads, interleaved and partly simultaneous → `R_BRAM_ADDR` wraps 7→0 six times. `frame_done` pulses exactly once and `busy` then falls. A 49th write or read leaves the addresses unchanged.
- `rst` asserted mid-row with all enables high → all outputs return to reset values on that edge, with no `frame_done`.
- 48 `en_e_mem_addr`, complete the frame, then `start` and 1 more `en_e_mem_addr` → `E_MEM_ADDR`=48 with the macro defined; 0 without it.

Source files
------------

// File: rtl/rb_addr_sequencer.sv
// rtl/rb_addr_sequencer.sv - row-buffer BRAM address sequencer with frame control
// Optional feature macro: ADDRGEN_MULTIFRAME_EN (keep E_MEM_ADDR running across frames).
module rb_addr_sequencer #(
    parameter int RBS      = 4,
    parameter int RB_DEPTH = 512,
    parameter int IMG_ROWS = 512,
    parameter int EMEM_AW  = 18
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                en_e_mem_addr,
    input  logic                                en_w_bram_addr,
    input  logic                                en_r_bram_addr,
    output logic [EMEM_AW-1:0]                  E_MEM_ADDR,
    output logic [$clog2(RBS*RB_DEPTH)-1:0]     W_BRAM_ADDR,
    output logic [$clog2(RB_DEPTH)-1:0]         R_BRAM_ADDR,
    output logic [$clog2(RBS)-1:0]              wr_row,
    output logic [$clog2(RBS)-1:0]              rd_top_row,
    output logic                                window_valid,
    output logic                                row_done,
    output logic                                frame_done,
    output logic                                busy
);

    localparam int LW = $clog2(RB_DEPTH);
    localparam int RW = $clog2(RBS);
    localparam int CW = $clog2(IMG_ROWS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [LW-1:0] wr_loc;
    logic [CW-1:0] rows_wr;
    logic [CW-1:0] rows_rd;

    logic wr_done, rd_done, do_wr, do_rd, wr_wrap, rd_wrap, wr_done_nxt, rd_done_nxt;

    always_comb begin
        wr_done     = (rows_wr == CW'(IMG_ROWS));
        rd_done     = (rows_rd == CW'(IMG_ROWS));
        do_wr       = (state == S_RUN) && en_w_bram_addr && !wr_done;
        do_rd       = (state == S_RUN) && en_r_bram_addr && !rd_done;
        wr_wrap     = do_wr && (wr_loc == LW'(RB_DEPTH - 1));
        rd_wrap     = do_rd && (R_BRAM_ADDR == LW'(RB_DEPTH - 1));
        // Completion seen one edge early so DONE is entered on the completing edge.
        wr_done_nxt = wr_done || (wr_wrap && (rows_wr == CW'(IMG_ROWS - 1)));
        rd_done_nxt = rd_done || (rd_wrap && (rows_rd == CW'(IMG_ROWS - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            E_MEM_ADDR   <= '1;
            W_BRAM_ADDR  <= '0;
            R_BRAM_ADDR  <= '0;
            wr_loc       <= '0;
            wr_row       <= '0;
            rd_top_row   <= RW'(1);
            rows_wr      <= '0;
            rows_rd      <= '0;
            window_valid <= 1'b0;
            row_done     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        W_BRAM_ADDR  <= '0;
                        R_BRAM_ADDR  <= '0;
                        wr_loc       <= '0;
                        wr_row       <= '0;
                        rd_top_row   <= RW'(1);
                        rows_wr      <= '0;
                        rows_rd      <= '0;
                        window_valid <= 1'b0;
`ifndef ADDRGEN_MULTIFRAME_EN
                        E_MEM_ADDR   <= '1;
`endif
                    end
                end
                S_RUN: begin
                    if (en_e_mem_addr)
                        E_MEM_ADDR <= E_MEM_ADDR + 1'b1;
                    if (do_wr) begin
                        // RBS is a power of two, so loc*RBS + wr_row is a concatenation.
                        W_BRAM_ADDR <= {wr_loc, wr_row};
                        wr_loc      <= wr_loc + 1'b1;
                        if (wr_wrap) begin
                            wr_row     <= wr_row + 1'b1;
                            rd_top_row <= wr_row + RW'(2);
                            row_done   <= 1'b1;
                            rows_wr    <= rows_wr + 1'b1;
                            if (rows_wr == CW'(RBS - 2))
                                window_valid <= 1'b1;
                        end
                    end
                    if (do_rd) begin
                        R_BRAM_ADDR <= R_BRAM_ADDR + 1'b1;
                        if (rd_wrap)
                            rows_rd <= rows_rd + 1'b1;
                    end
                    if (wr_done_nxt && rd_done_nxt) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb_addr_sequencer.sv
// tb/tb_rb_addr_sequencer.sv - directed self-checking bench for rb_addr_sequencer
module tb_rb_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, en_e, en_w, en_r;
    logic [17:0] e_addr;
    logic [4:0]  w_addr;
    logic [2:0]  r_addr;
    logic [1:0]  wr_row, rd_top_row;
    logic        window_valid, row_done, frame_done, busy;

    int checks = 0;
    int errors = 0;
    int wraps  = 0;
    int fd_cnt = 0;
    logic [2:0] prev_r;

    always #5 clk = ~clk;

    rb_addr_sequencer #(.RBS(4), .RB_DEPTH(8), .IMG_ROWS(6), .EMEM_AW(18)) dut (
        .clk(clk), .rst(rst), .start(start),
        .en_e_mem_addr(en_e), .en_w_bram_addr(en_w), .en_r_bram_addr(en_r),
        .E_MEM_ADDR(e_addr), .W_BRAM_ADDR(w_addr), .R_BRAM_ADDR(r_addr),
        .wr_row(wr_row), .rd_top_row(rd_top_row), .window_valid(window_valid),
        .row_done(row_done), .frame_done(frame_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic e, input logic w, input logic rd);
        rst = r; start = s; en_e = e; en_w = w; en_r = rd;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; en_e = 1'b0; en_w = 1'b0; en_r = 1'b0;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".e_addr"}, e_addr, 32'h3FFFF);
        chk({tag, ".w_addr"}, w_addr, 0);
        chk({tag, ".r_addr"}, r_addr, 0);
        chk({tag, ".wr_row"}, wr_row, 0);
        chk({tag, ".rd_top"}, rd_top_row, 1);
        chk({tag, ".wvalid"}, window_valid, 0);
        chk({tag, ".row_done"}, row_done, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        int n;
        int m;
        rst = 1'b1; start = 1'b0; en_e = 1'b0; en_w = 1'b0; en_r = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_reset("reset");
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        chk_reset("idle_hold");

        step(0, 1, 0, 0, 0);
        chk("start.busy", busy, 1);

        // 32 writes: interleaved addresses, row_done, window_valid
        for (int i = 1; i <= 32; i++) begin
            step(0, 0, 0, 1, 0);
            chk("wr.addr", w_addr, ((i - 1) % 8) * 4 + ((i - 1) / 8) % 4);
            chk("wr.row_done", row_done, (i % 8 == 0) ? 1 : 0);
            chk("wr.wr_row", wr_row, (i / 8) % 4);
            chk("wr.rd_top", rd_top_row, ((i / 8) + 1) % 4);
            chk("wr.wvalid", window_valid, (i >= 24) ? 1 : 0);
        end

        // 16 simultaneous write+read+emem cycles, then 32 read+emem cycles
        prev_r = r_addr;
        for (int j = 1; j <= 48; j++) begin
            n = 32 + j;
            m = j;
            if (j <= 16) step(0, 0, 1, 1, 1);
            else         step(0, 0, 1, 0, 1);
            if (j <= 16) chk("mix.w_addr", w_addr, ((n - 1) % 8) * 4 + ((n - 1) / 8) % 4);
            chk("mix.r_addr", r_addr, m % 8);
            if (prev_r == 3'd7 && r_addr == 3'd0) wraps++;
            prev_r = r_addr;
            chk("mix.frame_done", frame_done, (m == 48) ? 1 : 0);
            chk("mix.busy", busy, 1);
        end
        chk("mix.wraps", wraps, 6);
        chk("mix.wr_row", wr_row, 2);
        chk("mix.rd_top", rd_top_row, 3);
        chk("mix.e_addr", e_addr, 47);

        step(0, 0, 1, 1, 1);
        chk("done.frame_done", frame_done, 0);
        chk("done.busy", busy, 0);
        chk("done.w_addr", w_addr, 29);
        chk("done.r_addr", r_addr, 0);
        step(0, 0, 1, 1, 1);
        chk("idle.w_addr", w_addr, 29);
        chk("idle.r_addr", r_addr, 0);
        chk("idle.e_addr", e_addr, 47);
        chk("frame_done.count", fd_cnt, 1);

        // second frame: E_MEM_ADDR continuation depends on ADDRGEN_MULTIFRAME_EN
        step(0, 1, 0, 0, 0);
        chk("f2.busy", busy, 1);
        chk("f2.wr_row", wr_row, 0);
        chk("f2.wvalid", window_valid, 0);
        chk("f2.w_addr", w_addr, 0);
        step(0, 0, 1, 0, 0);
`ifdef ADDRGEN_MULTIFRAME_EN
        chk("f2.e_addr", e_addr, 48);
`else
        chk("f2.e_addr", e_addr, 0);
`endif

        // reset mid-row with all enables high
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("pre_rst.w_addr", w_addr, 4);
        fd_cnt = 0;
        step(1, 0, 1, 1, 1);
        chk_reset("mid_rst");
        step(0, 0, 1, 1, 1);
        chk_reset("post_rst");
        chk("post_rst.fd_count", fd_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
